// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache (4 x 16-bit words per line)
// with its miss-handling FSM between the memory stage and the backing memory.
module dcache_ctrl #(
  parameter int IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        DCacheReq,
  output logic        err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  o_dbg_state
);
  localparam int TAG_W = 13 - IDX_W;
  localparam int LINES = 1 << IDX_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2,
    S_CMPL = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_cnt;
  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TAG_W-1:0] r_tag_arr [LINES];
  logic [15:0]      r_line [LINES][4];

  // Request captured on a miss; the requester's inputs are ignored until CMPL.
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_off;
  logic [15:0]      r_wdata;
  logic             r_is_wr;

  logic [1:0]       w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_idle;
  logic             w_err;
  logic             w_accept;
  logic             w_hit;
  logic             w_idle_hit;
  logic             w_idle_miss;

  assign w_off       = Addr[2:1];
  assign w_idx       = Addr[2+IDX_W:3];
  assign w_tag       = Addr[15:3+IDX_W];
  assign w_idle      = (r_state == S_IDLE) && !rst;
  assign w_err       = (Rd && Wr) || (Addr[0] && (Rd || Wr));
  assign w_accept    = w_idle && (Rd ^ Wr) && !w_err;
  assign w_hit       = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
  assign w_idle_hit  = w_accept && w_hit;
  assign w_idle_miss = w_accept && !w_hit;
  assign o_dbg_state = r_state;

  // Status is combinational so hits complete with zero added latency.
  always_comb begin
    err       = w_idle && w_err;
    DCacheReq = w_accept;
    CacheHit  = w_idle_hit;
    Done      = w_idle_hit || ((r_state == S_CMPL) && !rst);
    Stall     = w_idle_miss || (((r_state == S_WB) || (r_state == S_FILL)) && !rst);
    DataOut   = 16'h0000;
    if (w_idle_hit && Rd)
      DataOut = r_line[w_idx][w_off];
    else if ((r_state == S_CMPL) && !rst && !r_is_wr)
      DataOut = r_line[r_idx][r_off];
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    if (!rst && (r_state == S_WB)) begin
      mem_req   = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = {r_tag_arr[r_idx], r_idx, r_cnt, 1'b0};
      mem_wdata = r_line[r_idx][r_cnt];
    end else if (!rst && (r_state == S_FILL)) begin
      mem_req   = 1'b1;
      mem_addr  = {r_tag, r_idx, r_cnt, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_valid <= '0;
      r_dirty <= '0;
      r_tag   <= '0;
      r_idx   <= '0;
      r_off   <= 2'd0;
      r_wdata <= 16'h0000;
      r_is_wr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_idle_hit && Wr) begin
            r_line[w_idx][w_off] <= DataIn;
            r_dirty[w_idx]       <= 1'b1;
          end else if (w_idle_miss) begin
            r_tag   <= w_tag;
            r_idx   <= w_idx;
            r_off   <= w_off;
            r_wdata <= DataIn;
            r_is_wr <= Wr;
            r_cnt   <= 2'd0;
            r_state <= (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_FILL;
          end
        end
        S_WB: begin
          if (mem_ack) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_cnt   <= 2'd0;
              r_state <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            r_line[r_idx][r_cnt] <= mem_rdata;
            r_cnt                <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_tag_arr[r_idx] <= r_tag;
              r_valid[r_idx]   <= 1'b1;
              r_dirty[r_idx]   <= 1'b0;
              r_state          <= S_CMPL;
            end
          end
        end
        S_CMPL: begin
          if (r_is_wr) begin
            r_line[r_idx][r_off] <= r_wdata;
            r_dirty[r_idx]       <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
